seq_divider: RTL and testbench

- Sequential restoring divider; the inverse operator to the team's 8x8 combinational Braun multiplier.
- Takes a 2W-bit dividend (a product-width value) and a W-bit divisor, and produces a 2W-bit quotient and a W-bit remainder.
- Computes one quotient bit per clock behind a start/busy/done handshake.
- Intended for the same TinyTapeout user area, alongside the multiplier, so products can be checked by round-trip.

---
 rtl/seq_divider.sv | 121 ++++++++++++
 tb/tb_seq_divider.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake.
module seq_divider #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] quotient,
   output logic [W-1:0]   remainder,
   output logic           div_by_zero,
   output logic           dbg_state_o
);

   // Handshake: start is sampled only in IDLE; the accepting edge captures the
   // operands. busy is high during RUN; done is a one-cycle pulse on the edge
   // the results are loaded, and the results hold until the next completion.

   localparam int CW = $clog2(2 * W);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W:0]       prem_q, prem_d;
   logic [2*W-1:0]   shreg_q, shreg_d;
   logic [W-1:0]     dvsr_q, dvsr_d;
   logic [2*W-1:0]   quot_q, quot_d;
   logic [W-1:0]     rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [W:0]       shifted;
   logic [W:0]       diff;
   logic             qbit;

   // Partial remainder is W+1 bits so the trial subtraction cannot wrap.
   assign shifted = {prem_q[W-1:0], shreg_q[2*W-1]};
   assign diff    = shifted - {1'b0, dvsr_q};
   assign qbit    = ~diff[W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      shreg_d = shreg_q;
      dvsr_d  = dvsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvsr_d = divisor;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  quot_d = '1;
                  rem_d  = dividend[W-1:0];
                  dbz_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  cnt_d   = CW'(2 * W - 1);
                  prem_d  = '0;
                  shreg_d = dividend;
               end
            end
         end
         RUN: begin
            // Dividend bits shift out the top while quotient bits fill the bottom.
            prem_d  = qbit ? diff : shifted;
            shreg_d = {shreg_q[2*W-2:0], qbit};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               quot_d  = {shreg_q[2*W-2:0], qbit};
               rem_d   = qbit ? diff[W-1:0] : shifted[W-1:0];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         shreg_q <= '0;
         dvsr_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         shreg_q <= shreg_d;
         dvsr_q  <= dvsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases from the test plan plus
// a long held-start run scored against plain integer division.
module tb_seq_divider;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [2*W-1:0] quotient;
   logic [W-1:0]   remainder;
   logic           div_by_zero;
   logic           dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Scoreboard entries: {dividend, divisor} of each accepted request.
   logic [3*W-1:0] exp_q[$];

   seq_divider #(.W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver ----------------
   // Issues one request and returns the outputs at the done pulse.
   // lat counts edges from the accepting edge to the done edge.
   task automatic run_div(input logic [2*W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat, output int bcnt,
                          output logic [2*W-1:0] q_early);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      q_early = quotient;
      lat     = 0;
      bcnt    = 0;
      while (1) begin
         if (busy) bcnt++;
         if (done) break;
         if (lat >= 40) break;
         @(negedge clk);
         lat++;
         dividend = 16'($urandom);
         divisor  = 8'($urandom);
      end
      q  = quotient;
      r  = remainder;
      dz = div_by_zero;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
                  busy, done, quotient, remainder, div_by_zero);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [2*W-1:0] va [4] = '{16'd65025, 16'd1000, 16'd65535, 16'd0};
      logic [W-1:0]   vb [4] = '{8'd255, 8'd7, 8'd1, 8'd5};
      logic [2*W-1:0] q, qe, prev_q;
      logic [W-1:0]   r;
      logic           dz;
      int             lat, bc;
      prev_q = '0;
      for (int i = 0; i < 4; i++) begin
         run_div(va[i], vb[i], q, r, dz, lat, bc, qe);
         n_checks++;
         if (qe !== prev_q) begin
            n_fail++;
            $display("FAIL hold_on_start[%0d]: q=%0d, want held %0d", i, qe, prev_q);
         end
         n_checks++;
         if (lat !== 16) begin
            n_fail++;
            $display("FAIL latency[%0d]: got %0d, want 16", i, lat);
         end
         n_checks++;
         if (bc !== 16) begin
            n_fail++;
            $display("FAIL busy_cycles[%0d]: got %0d, want 16", i, bc);
         end
         n_checks++;
         if (q !== va[i] / 16'(vb[i]) || r !== 8'(va[i] % 16'(vb[i])) || dz !== 1'b0) begin
            n_fail++;
            $display("FAIL basic[%0d] %0d/%0d: q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                     i, va[i], vb[i], q, r, dz, va[i] / 16'(vb[i]), va[i] % 16'(vb[i]));
         end
         prev_q = va[i] / 16'(vb[i]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || quotient !== prev_q) begin
         n_fail++;
         $display("FAIL done_pulse_hold: done=%b q=%0d, want done=0 q=%0d", done, quotient, prev_q);
      end
   endtask

   task automatic test_zero_divisor();
      logic [2*W-1:0] q, qe;
      logic [W-1:0]   r;
      logic           dz;
      int             lat, bc;
      run_div(16'd300, 8'd0, q, r, dz, lat, bc, qe);
      n_checks++;
      if (lat !== 0 || bc !== 0) begin
         n_fail++;
         $display("FAIL dbz_timing: lat=%0d busy_cycles=%0d, want 0 and 0", lat, bc);
      end
      n_checks++;
      if (q !== 16'hFFFF || r !== 8'h2C || dz !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_result: q=%h r=%h dz=%b, want ffff 2c 1", q, r, dz);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_pulse: done=%b dz=%b, want 0 1", done, div_by_zero);
      end
      run_div(16'd10, 8'd3, q, r, dz, lat, bc, qe);
      n_checks++;
      if (q !== 16'd3 || r !== 8'd1 || dz !== 1'b0 || lat !== 16) begin
         n_fail++;
         $display("FAIL after_dbz: q=%0d r=%0d dz=%b lat=%0d, want 3 1 0 16", q, r, dz, lat);
      end
   endtask

   task automatic test_start_while_busy();
      int lat;
      @(negedge clk);
      dividend = 16'd500;
      divisor  = 8'd9;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      repeat (4) begin
         @(negedge clk);
         lat++;
      end
      dividend = 16'd50000;
      divisor  = 8'd3;
      start    = 1'b1;
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (quotient !== 16'd55 || remainder !== 8'd5 || lat !== 16) begin
         n_fail++;
         $display("FAIL start_while_busy: q=%0d r=%0d lat=%0d, want 55 5 16", quotient, remainder, lat);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL ignored_start_restart: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [2*W-1:0] q, qe;
      logic [W-1:0]   r;
      logic           dz;
      int             lat, bc;
      int             seen_done;
      @(negedge clk);
      dividend = 16'd40000;
      divisor  = 8'd200;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d dz=%b, want all zero",
                  busy, done, quotient, remainder, div_by_zero);
      end
      seen_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      n_checks++;
      if (seen_done !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: saw %0d done/busy samples, want 0", seen_done);
      end
      run_div(16'd40000, 8'd200, q, r, dz, lat, bc, qe);
      n_checks++;
      if (q !== 16'd200 || r !== 8'd0 || lat !== 16) begin
         n_fail++;
         $display("FAIL after_reset: q=%0d r=%0d lat=%0d, want 200 0 16", q, r, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [3*W-1:0] e;
      logic [2*W-1:0] ea;
      logic [W-1:0]   eb;
      int done_cnt, last_acc, acc_cyc, guard;
      logic prev_busy;
      done_cnt  = 0;
      last_acc  = -1;
      acc_cyc   = 0;
      guard     = 0;
      prev_busy = 1'b0;
      @(negedge clk);
      dividend = 16'($urandom_range(0, 65535));
      divisor  = 8'($urandom_range(1, 255));
      start    = 1'b1;
      while (done_cnt < 200 && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (busy && !prev_busy) begin
            acc_cyc = cyc;
            exp_q.push_back({dividend, divisor});
            // Each completion's edge is followed directly by the next accept.
            if (last_acc >= 0) begin
               n_checks++;
               if (acc_cyc - last_acc !== 17) begin
                  n_fail++;
                  $display("FAIL accept_spacing: %0d edges, want 17", acc_cyc - last_acc);
               end
            end
            last_acc = acc_cyc;
            dividend = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300))
                                                   : 16'($urandom_range(0, 65535));
            divisor  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4))
                                                   : 8'($urandom_range(1, 255));
         end
         prev_busy = busy;
         if (done) begin
            done_cnt++;
            if (done_cnt == 200) start = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_unexpected_done: q=%0d r=%0d, want no done", quotient, remainder);
            end else begin
               e  = exp_q.pop_front();
               ea = e[3*W-1:W];
               eb = e[W-1:0];
               if (quotient !== ea / 16'(eb) || remainder !== 8'(ea % 16'(eb))
                   || 32'(quotient) * 32'(eb) + 32'(remainder) !== 32'(ea)
                   || remainder >= eb || div_by_zero !== 1'b0 || cyc - acc_cyc !== 16) begin
                  n_fail++;
                  $display("FAIL b2b[%0d] %0d/%0d: q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d dz=0 lat=16",
                           done_cnt, ea, eb, quotient, remainder, div_by_zero, cyc - acc_cyc,
                           ea / 16'(eb), ea % 16'(eb));
               end
            end
         end
      end
      start = 1'b0;
      n_checks++;
      if (done_cnt !== 200) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d completions, want 200", done_cnt);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_zero_divisor();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
